// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequences byte/half/word/dword load and store requests onto a
//            single-ported 64-bit memory (2048 dword slots). Accesses that
//            cross an 8-byte boundary become two dword transactions. Load data
//            is extracted, merged and sign/zero-extended.
// Ports    : clk, rst (async, active-high)
//            req_*      : request handshake (req_ready high only in IDLE)
//            resp_*     : one-cycle completion pulse plus extended load data
//            mem_*      : memory pins (addr/data/mask/shift/rw/enable)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [13:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [10:0] mem_addr,
    inout  wire  [63:0] mem_data,
    output logic [7:0]  mem_mask,
    output logic [5:0]  mem_shift,
    output logic        mem_rw,
    output logic        mem_enable
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_A   = 3'd1,
        S_LD_A_W = 3'd2,
        S_LD_B   = 3'd3,
        S_LD_B_W = 3'd4,
        S_ST_A   = 3'd5,
        S_ST_B   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [13:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] lo_q, lo_d;
    logic [63:0] hi_q, hi_d;
    logic [63:0] rdata_q, rdata_d;

    logic [2:0]  w_off;
    logic [3:0]  w_nbytes;
    logic [3:0]  w_inv_off;
    logic        w_split;
    logic [10:0] w_blk_a;
    logic [10:0] w_blk_b;
    logic [7:0]  w_mask_base;
    logic [63:0] w_lo_n;
    logic [63:0] w_hi_n;
    logic [63:0] w_raw;
    logic [63:0] w_ext;
    logic [63:0] w_bus_wdata;

    assign w_off     = addr_q[2:0];
    assign w_nbytes  = 4'd1 << size_q;
    assign w_inv_off = 4'd8 - {1'b0, w_off};
    assign w_split   = ({1'b0, w_off} + w_nbytes) > 4'd8;
    assign w_blk_a   = addr_q[13:3];
    assign w_blk_b   = w_blk_a + 11'd1;   // wraps 0x7FF -> 0x000

    always_comb begin
        case (size_q)
            2'd0:    w_mask_base = 8'h01;
            2'd1:    w_mask_base = 8'h03;
            2'd2:    w_mask_base = 8'h0F;
            default: w_mask_base = 8'hFF;
        endcase
    end

    // The halves as they will be after this edge, so the result can be
    // registered on the same edge that samples the last memory beat.
    assign w_lo_n = (state_q == S_LD_A_W) ? mem_data : lo_q;
    assign w_hi_n = (state_q == S_LD_B_W) ? mem_data : hi_q;
    assign w_raw  = 64'({w_hi_n, w_lo_n} >> {w_off, 3'b000});

    always_comb begin
        case (size_q)
            2'd0:    w_ext = uns_q ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
            2'd1:    w_ext = uns_q ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
            2'd2:    w_ext = uns_q ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        rdata_d     = rdata_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_addr    = 11'd0;
        mem_mask    = 8'd0;
        mem_shift   = 6'd0;
        mem_rw      = 1'b0;
        mem_enable  = 1'b0;
        w_bus_wdata = 64'd0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    hi_d    = 64'd0;   // upper half stays zero for unsplit loads
                    state_d = req_we ? S_ST_A : S_LD_A;
                end
            end
            S_LD_A: begin
                mem_addr   = w_blk_a;
                mem_enable = 1'b1;
                state_d    = S_LD_A_W;
            end
            S_LD_A_W: begin
                mem_addr   = w_blk_a;
                mem_enable = 1'b1;
                lo_d       = mem_data;
                state_d    = w_split ? S_LD_B : S_DONE;
            end
            S_LD_B: begin
                mem_addr   = w_blk_b;
                mem_enable = 1'b1;
                state_d    = S_LD_B_W;
            end
            S_LD_B_W: begin
                mem_addr   = w_blk_b;
                mem_enable = 1'b1;
                hi_d       = mem_data;
                state_d    = S_DONE;
            end
            S_ST_A: begin
                mem_addr    = w_blk_a;
                mem_enable  = 1'b1;
                mem_rw      = 1'b1;
                w_bus_wdata = wdata_q;
                mem_shift   = {w_off, 3'b000};
                mem_mask    = w_mask_base << w_off;
                state_d     = w_split ? S_ST_B : S_DONE;
            end
            S_ST_B: begin
                mem_addr    = w_blk_b;
                mem_enable  = 1'b1;
                mem_rw      = 1'b1;
                w_bus_wdata = wdata_q >> {w_inv_off, 3'b000};
                mem_mask    = w_mask_base >> w_inv_off;
                state_d     = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // DONE is only ever entered from an access state, so this fires once
        // per operation.
        if (state_d == S_DONE) begin
            rdata_d = we_q ? 64'd0 : w_ext;
        end
    end

    assign mem_data = (mem_enable & mem_rw) ? w_bus_wdata : 64'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 14'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 64'd0;
            lo_q    <= 64'd0;
            hi_q    <= 64'd0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rdata_q <= rdata_d;
        end
    end

    assign resp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit: a registered-read memory
//            model on the pins, a byte-level reference memory, and a
//            scoreboard queue popped by an independent response monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [13:0] req_addr = 14'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [10:0] mem_addr;
    wire  [63:0] mem_data;
    logic [7:0]  mem_mask;
    logic [5:0]  mem_shift;
    logic        mem_rw;
    logic        mem_enable;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_mask(mem_mask),
        .mem_shift(mem_shift), .mem_rw(mem_rw), .mem_enable(mem_enable)
    );

    // ---------------- pin-level memory model ----------------
    logic [63:0] emem [0:2047];
    logic [63:0] rdreg = 64'd0;
    logic        do_init = 1'b0;
    wire  [63:0] wr_shifted = mem_data << mem_shift;

    function automatic logic [63:0] init_word(input int j);
        logic [31:0] a;
        a = j;
        return {a * 32'h9E3779B1, (a ^ 32'h5A5A5A5A) * 32'h85EBCA6B};
    endfunction

    assign mem_data = (mem_enable && !mem_rw) ? rdreg : 64'bz;

    always @(posedge clk) begin
        if (do_init) begin
            for (int j = 0; j < 2048; j++) emem[j] <= init_word(j);
        end else if (mem_enable) begin
            if (mem_rw) begin
                for (int i = 0; i < 8; i++)
                    if (mem_mask[i]) emem[mem_addr][8*i +: 8] <= wr_shifted[8*i +: 8];
            end else begin
                rdreg <= emem[mem_addr];
            end
        end
    end

    // ---------------- reference byte memory ----------------
    logic [7:0] gmem [0:16383];

    function automatic logic [63:0] model_load(input logic [13:0] a, input logic [1:0] sz,
                                               input logic u);
        int n;
        logic [63:0] v;
        logic [13:0] ba;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            ba = a + 14'(i);
            v[8*i +: 8] = gmem[ba];
        end
        if (!u && n < 8 && v[8*n-1])
            for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
        return v;
    endfunction

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] rdata; int acyc; int lat; } exp_t;
    exp_t sbq[$];

    typedef struct { logic [10:0] a; logic [7:0] m; logic [5:0] s; logic [63:0] d; } wr_t;
    wr_t         wlog[$];
    logic [10:0] rlog[$];

    always @(negedge clk) begin
        if (!rst && mem_enable) begin
            if (mem_rw) wlog.push_back('{mem_addr, mem_mask, mem_shift, mem_data});
            else        rlog.push_back(mem_addr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- response monitor ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%h required=none", resp_rdata);
            end else begin
                e = sbq.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("latency", 64'(cyc - e.acyc + 1), 64'(e.lat));
                check("ready_low_in_done", 64'(req_ready), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic we, input logic [13:0] a, input logic [1:0] sz,
                         input logic u, input logic [63:0] wd, input bit track = 1'b1);
        int t;
        int n;
        bit split;
        logic [63:0] expv;
        logic [13:0] ba;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
            return;
        end
        req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = 14'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = {$urandom, $urandom};
        n     = 1 << sz;
        split = (int'(a[2:0]) + n) > 8;
        if (we) begin
            expv = 64'd0;
            if (track)
                for (int i = 0; i < n; i++) begin
                    ba = a + 14'(i);
                    gmem[ba] = wd[8*i +: 8];
                end
        end else begin
            expv = model_load(a, sz, u);
        end
        if (track)
            sbq.push_back('{expv, cyc, we ? (split ? 3 : 2) : (split ? 5 : 3)});
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sbq.size() != 0 || !req_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=%0d required=0 pending", sbq.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] w;
        logic [13:0] ra;
        for (int j = 0; j < 2048; j++) begin
            w = init_word(j);
            for (int i = 0; i < 8; i++) gmem[8*j + i] = w[8*i +: 8];
        end

        // reset asserted mid-cycle
        #3 rst = 1'b1;
        #1;
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata,      64'd0);
        check("rst_mem_enable", 64'(mem_enable), 64'd0);
        check("rst_mem_rw",     64'(mem_rw),     64'd0);
        check("rst_mem_mask",   64'(mem_mask),   64'd0);
        check("rst_mem_shift",  64'(mem_shift),  64'd0);
        check("rst_mem_addr",   64'(mem_addr),   64'd0);
        do_init = 1'b1;
        @(posedge clk);
        #1 do_init = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // aligned dword store then load
        wlog.delete();
        issue(1'b1, 14'h0010, 2'd3, 1'b0, 64'h1122334455667788);
        wait_idle();
        check("dw_st_beats", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) begin
            check("dw_st_addr",  64'(wlog[0].a), 64'd2);
            check("dw_st_mask",  64'(wlog[0].m), 64'hFF);
            check("dw_st_shift", 64'(wlog[0].s), 64'd0);
            check("dw_st_data",  wlog[0].d,      64'h1122334455667788);
        end
        issue(1'b0, 14'h0010, 2'd3, 1'b0, 64'd0);
        wait_idle();

        // byte store and sign/zero-extended loads
        wlog.delete();
        issue(1'b1, 14'h000B, 2'd0, 1'b0, 64'h80);
        wait_idle();
        check("b_st_beats", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) begin
            check("b_st_addr",  64'(wlog[0].a), 64'd1);
            check("b_st_mask",  64'(wlog[0].m), 64'h08);
            check("b_st_shift", 64'(wlog[0].s), 64'd24);
        end
        issue(1'b0, 14'h000B, 2'd0, 1'b0, 64'd0);
        issue(1'b0, 14'h000B, 2'd0, 1'b1, 64'd0);
        wait_idle();

        // split word store / load
        wlog.delete();
        issue(1'b1, 14'h0016, 2'd2, 1'b0, 64'hAABBCCDD);
        wait_idle();
        check("sw_st_beats", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 2) begin
            check("sw_a_addr",  64'(wlog[0].a), 64'd2);
            check("sw_a_mask",  64'(wlog[0].m), 64'hC0);
            check("sw_a_shift", 64'(wlog[0].s), 64'd48);
            check("sw_b_addr",  64'(wlog[1].a), 64'd3);
            check("sw_b_mask",  64'(wlog[1].m), 64'h03);
            check("sw_b_shift", 64'(wlog[1].s), 64'd0);
            check("sw_b_data",  wlog[1].d,      64'hAABB);
        end
        issue(1'b0, 14'h0016, 2'd2, 1'b1, 64'd0);
        issue(1'b0, 14'h0016, 2'd2, 1'b0, 64'd0);
        wait_idle();

        // wrap-around dword load
        rlog.delete();
        issue(1'b0, 14'h3FFC, 2'd3, 1'b0, 64'd0);
        wait_idle();
        check("wrap_beats", 64'(rlog.size()), 64'd4);
        if (rlog.size() >= 4) begin
            check("wrap_a0", 64'(rlog[0]), 64'h7FF);
            check("wrap_a1", 64'(rlog[1]), 64'h7FF);
            check("wrap_b0", 64'(rlog[2]), 64'h000);
            check("wrap_b1", 64'(rlog[3]), 64'h000);
        end

        // reset between ST_A and ST_B of a split store
        issue(1'b1, 14'h0016, 2'd2, 1'b0, 64'h11223344, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req_ready",  64'(req_ready),  64'd1);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_mem_enable", 64'(mem_enable), 64'd0);
        check("mid_rst_mem_rw",     64'(mem_rw),     64'd0);
        check("mid_rst_mem_mask",   64'(mem_mask),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_lo_bytes", 64'(emem[2][63:48]), 64'h3344);
        check("mid_rst_hi_bytes", 64'(emem[3][15:0]),  64'({gmem[14'h19], gmem[14'h18]}));
        gmem[14'h16] = 8'h44;
        gmem[14'h17] = 8'h33;
        issue(1'b0, 14'h0016, 2'd2, 1'b1, 64'd0);
        wait_idle();

        // randomized traffic
        for (int k = 0; k < 200; k++) begin
            ra = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 95)) : 14'($urandom);
            issue(($urandom_range(0, 4) < 2), ra, 2'($urandom), 1'($urandom),
                  {$urandom, $urandom});
        end
        wait_idle();
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the core's load/store requests and the single-ported 64-bit `Memory` array. It accepts one byte/half/word/double access per handshake and drives the memory's `addr`/`data`/`mask`/`shift`/`rw`/`enable` pins. An access that crosses an 8-byte boundary is split into two dword transactions. Load data is extracted, merged and sign- or zero-extended before it is returned.

## Interface
Parameters: none (memory geometry fixed: 14-bit byte address, 2048 dword slots).
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  14  byte address
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- `req_unsigned`  in  1  loads: zero-extend when 1, sign-extend when 0
- `req_wdata`  in  64  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion pulse, no backpressure
- `resp_rdata`  out  64  extended load data; 0 for stores
- `mem_addr`  out  11  dword index, connects to memory `addr[13:3]`
- `mem_data`  inout  64  driven only when `mem_enable & mem_rw`, else Z
- `mem_mask`  out  8  byte write enables
- `mem_shift`  out  6  left shift the memory applies to write data
- `mem_rw`  out  1  1 = write
- `mem_enable`  out  1  memory select

## Operation
- Accept on `req_valid & req_ready`. Register we/addr/size/unsigned/wdata at acceptance; later changes on the `req_*` inputs are ignored.
- Derived values:
  - nbytes = 1 << size
  - off = addr[2:0]
  - split = (off + nbytes > 8)
  - A = addr[13:3]
  - B = A + 1, 11-bit wrap: 0x7FF + 1 = 0x000
- States: IDLE, LD_A, LD_A_W, LD_B, LD_B_W, ST_A, ST_B, DONE.
- From IDLE on accept: the next state is ST_A if we, else LD_A.
- LD_A and LD_A_W: mem_addr = A, enable = 1, rw = 0. At the end of LD_A_W, capture `mem_data` into lo.
- After LD_A_W: go to LD_B if split, else DONE.
- LD_B and LD_B_W: the same, with mem_addr = B. At the end of LD_B_W, capture into hi.
- ST_A: mem_addr = A, rw = 1, enable = 1, mem_data = wdata, mem_shift = off*8, mem_mask = (((1<<nbytes)-1) << off)[7:0]. Next state is ST_B if split, else DONE.
- ST_B: mem_addr = B, rw = 1, enable = 1, mem_data = wdata >> ((8-off)*8), mem_shift = 0, mem_mask = ((1<<nbytes)-1) >> (8-off). Next state is DONE.
- DONE: resp_valid = 1 for one cycle, then IDLE.
- Load result:
  - t = ({hi, lo} >> off*8), keep the low nbytes bytes; hi = 0 when not split.
  - Extend to 64 bits using bit (nbytes*8-1) when signed; zero-extend when unsigned.
  - Size 3 passes through unchanged.
- resp_rdata holds its value until the next DONE.
- Outside the active states: enable = 0, rw = 0, mask = 0, shift = 0, mem_data = Z.

## Timing
- Reset values:
  - state = IDLE
  - req_ready = 1
  - resp_valid = 0
  - resp_rdata = 0
  - mem_addr = 0, mem_mask = 0, mem_shift = 0
  - mem_rw = 0, mem_enable = 0
  - mem_data released to Z
- Latency, from accept edge to resp_valid high:
  - aligned load: 3 cycles
  - split load: 5 cycles
  - aligned store: 2 cycles
  - split store: 3 cycles
- The memory registers read data on the edge ending LD_x. The LSU holds the same address with enable = 1, rw = 0 through LD_x_W and samples at the end of LD_x_W.
- No new request is accepted during DONE; req_ready rises in the cycle after DONE.
- Reset asserted mid-operation:
  - Go to IDLE at once; drop enable/rw and release the bus combinationally.
  - Discard the pending access and emit no resp_valid.
  - Any ST_A write already committed stays in memory; there is no rollback.
- Stores are strictly ordered before any following load, because there is only one access in flight.

## Test plan
- Reset: assert rst mid-cycle -> req_ready = 1, resp_valid = 0, mem_enable = 0, mem_mask = 0, mem_data = Z immediately.
- Aligned dword: store 0x1122334455667788 at 0x0010 -> ST_A with mem_addr 2, mask 0xFF, shift 0, resp 2 cycles after accept. Then load dword at 0x0010 -> 0x1122334455667788, resp 3 cycles after accept.
- Byte extension: store byte 0x80 at 0x000B -> mask 0x08, shift 24. Signed byte load -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x0000000000000080.
- Split word at 0x0016, wdata 0xAABBCCDD:
  - ST_A: mem_addr 2, mask 0xC0, shift 48.
  - ST_B: mem_addr 3, mask 0x03, data 0xAABB, shift 0.
  - Unsigned word load at 0x0016 -> 0xAABBCCDD after 5 cycles.
- Wrap: dword load at 0x3FFC -> LD_A at mem_addr 0x7FF, LD_B at 0x000. The result is the high 4 bytes of dword 0x7FF followed by the low 4 bytes of dword 0.
- Reset between ST_A and ST_B of the 0x0016 store -> bytes 0x16–0x17 written, 0x18–0x19 unchanged, no resp_valid, req_ready = 1.
